mxu_sequencer: RTL and testbench

- Command-driven controller that runs one GRID_SIZE x GRID_SIZE matrix multiply on the systolic MXU.
- Fetches A and B tiles from scratchpad memory and drives skewed west/north operand streams with ce.
- Waits for the array to drain, writes the C tile back to memory, then pulses done.
- Replaces hand-staged multiply sequencing in the accelerator top level; the top-level decoder issues one command per mat-mult instruction.

---
 rtl/mxu_sequencer.sv | 146 ++++++++++++++
 tb/tb_mxu_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_sequencer.sv
// rtl/mxu_sequencer.sv - command-driven sequencer for one GxG matrix multiply on the systolic MXU
module mxu_sequencer #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2,
    parameter int ADDR_W    = 5,
    parameter int MXU_LAT   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [ADDR_W-1:0]                 cmd_a_addr,
    input  logic [ADDR_W-1:0]                 cmd_b_addr,
    input  logic [ADDR_W-1:0]                 cmd_c_addr,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic [NUM_SIZE-1:0]               rd_data,
    output logic                              wr_en,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [NUM_SIZE-1:0]               wr_data,
    output logic                              mxu_ce,
    output logic                              mxu_clr,
    output logic [NUM_SIZE*GRID_SIZE-1:0]     west_input,
    output logic [NUM_SIZE*GRID_SIZE-1:0]     north_input,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_out,
    output logic                              busy,
    output logic                              done
);

    localparam int G  = GRID_SIZE;
    localparam int GG = G * G;
    localparam int NT = 2 * GG;

    localparam logic [7:0] LOAD_LAST  = 8'(NT);
    localparam logic [7:0] FEED_LAST  = 8'(3 * G - 3 + MXU_LAT);
    localparam logic [7:0] WRITE_LAST = 8'(GG - 1);
    localparam logic [7:0] GG8        = 8'(GG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [7:0]                 cnt;
    logic [ADDR_W-1:0]          a_addr;
    logic [ADDR_W-1:0]          b_addr;
    logic [ADDR_W-1:0]          c_addr;
    logic [NUM_SIZE-1:0]        tile     [NT];
    logic [NUM_SIZE-1:0]        tile_nxt [NT];
    logic                       capture;
    logic [7:0]                 feed_t;
    logic [NUM_SIZE*G-1:0]      west_nxt;
    logic [NUM_SIZE*G-1:0]      north_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid)          state_nxt = S_LOAD;
            S_LOAD:  if (cnt == LOAD_LAST)   state_nxt = S_FEED;
            S_FEED:  if (cnt == FEED_LAST)   state_nxt = S_WRITE;
            S_WRITE: if (cnt == WRITE_LAST)  state_nxt = S_DONE;
            S_DONE:                          state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        mxu_ce    = (state == S_FEED);
        mxu_clr   = (state == S_LOAD) && (cnt == 8'd0);
        rd_en     = (state == S_LOAD) && (cnt < LOAD_LAST);
        rd_addr   = '0;
        if (rd_en) begin
            if (cnt < GG8) rd_addr = a_addr + ADDR_W'(cnt);
            else           rd_addr = b_addr + ADDR_W'(cnt - GG8);
        end
        wr_en   = (state == S_WRITE);
        wr_addr = wr_en ? (c_addr + ADDR_W'(cnt)) : '0;
        wr_data = '0;
        if (wr_en) begin
            for (int k = 0; k < GG; k++) begin
                if (cnt == 8'(k)) wr_data = result_out[k*NUM_SIZE +: NUM_SIZE];
            end
        end
    end

    // Read data lands one cycle after its strobe; a shift chain leaves A in 0..GG-1 and B above it.
    always_comb begin
        capture = (state == S_LOAD) && (cnt != 8'd0);
        for (int i = 0; i < NT; i++) tile_nxt[i] = tile[i];
        if (capture) begin
            for (int i = 0; i < NT - 1; i++) tile_nxt[i] = tile[i+1];
            tile_nxt[NT-1] = rd_data;
        end
    end

    // Operands are registered one cycle ahead, so they use the post-capture tile view.
    always_comb begin
        feed_t    = (state == S_FEED) ? (cnt + 8'd1) : 8'd0;
        west_nxt  = '0;
        north_nxt = '0;
        for (int i = 0; i < G; i++) begin
            for (int k = 0; k < G; k++) begin
                if (feed_t == 8'(i + k)) west_nxt[i*NUM_SIZE +: NUM_SIZE] = tile_nxt[i*G + k];
            end
        end
        for (int j = 0; j < G; j++) begin
            for (int r = 0; r < G; r++) begin
                if (feed_t == 8'(r + j)) north_nxt[j*NUM_SIZE +: NUM_SIZE] = tile_nxt[GG + r*G + j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            a_addr      <= '0;
            b_addr      <= '0;
            c_addr      <= '0;
            west_input  <= '0;
            north_input <= '0;
            for (int i = 0; i < NT; i++) tile[i] <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || (state == S_IDLE)) cnt <= 8'd0;
            else                                           cnt <= cnt + 8'd1;
            if ((state == S_IDLE) && cmd_valid) begin
                a_addr <= cmd_a_addr;
                b_addr <= cmd_b_addr;
                c_addr <= cmd_c_addr;
            end
            for (int i = 0; i < NT; i++) tile[i] <= tile_nxt[i];
            west_input  <= (state_nxt == S_FEED) ? west_nxt  : '0;
            north_input <= (state_nxt == S_FEED) ? north_nxt : '0;
        end
    end

endmodule

// File: tb/tb_mxu_sequencer.sv
// tb/tb_mxu_sequencer.sv - directed scoreboard bench for mxu_sequencer with memory and MXU models
module tb_mxu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_a_addr;
    logic [4:0]  cmd_b_addr;
    logic [4:0]  cmd_c_addr;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        mxu_ce;
    logic        mxu_clr;
    logic [31:0] west_input;
    logic [31:0] north_input;
    logic [63:0] result_out;
    logic        busy;
    logic        done;

    mxu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mxu_ce(mxu_ce), .mxu_clr(mxu_clr),
        .west_input(west_input), .north_input(north_input),
        .result_out(result_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scratchpad with a bench-side preload port
    logic [15:0] mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we)     mem[pre_addr] <= pre_data;
        else if (wr_en) mem[wr_addr]  <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // behavioural 2x2 output-stationary systolic array
    logic [15:0] acc [2][2];
    logic [15:0] ar  [2][2];
    logic [15:0] br  [2][2];
    logic [15:0] a_in [2][2];
    logic [15:0] b_in [2][2];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_in[i][0] = west_input[i*16 +: 16];
            b_in[0][i] = north_input[i*16 +: 16];
            a_in[i][1] = ar[i][0];
            b_in[1][i] = br[0][i];
        end
        for (int k = 0; k < 4; k++) result_out[k*16 +: 16] = acc[k/2][k%2];
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || mxu_clr) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
                end
        end else if (mxu_ce) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
                    ar[i][j]  <= a_in[i][j];
                    br[i][j]  <= b_in[i][j];
                end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0]  exp_rd [$];
    logic [20:0] exp_wr [$];
    int clr_cnt = 0;
    int clr_cyc = -1;
    int busy_low = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [4:0]  re_exp;
    logic [20:0] we_exp;
    always @(negedge clk) begin
        if (mxu_clr) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (rd_en) begin
            chk("rd_wr_overlap", wr_en, 1'b0);
            n_cmp++;
            assert (exp_rd.size() != 0) else begin
                n_err++;
                $error("FAIL rd_unexpected: observed read at %0d expected none", rd_addr);
            end
            if (exp_rd.size() != 0) begin
                re_exp = exp_rd.pop_front();
                chk("rd_addr", rd_addr, re_exp);
            end
        end
        if (wr_en) begin
            n_cmp++;
            assert (exp_wr.size() != 0) else begin
                n_err++;
                $error("FAIL wr_unexpected: observed write at %0d expected none", wr_addr);
            end
            if (exp_wr.size() != 0) begin
                we_exp = exp_wr.pop_front();
                chk("wr_addr", wr_addr, we_exp[20:16]);
                chk("wr_data", wr_data, we_exp[15:0]);
            end
        end
    end

    task automatic push_exp(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        logic [15:0] s;
        for (int k = 0; k < 4; k++) exp_rd.push_back(a + 5'(k));
        for (int k = 0; k < 4; k++) exp_rd.push_back(b + 5'(k));
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = '0;
                for (int k = 0; k < 2; k++) s = s + mem[a + 5'(i*2+k)] * mem[b + 5'(k*2+j)];
                exp_wr.push_back({c + 5'(i*2+j), s});
            end
    endtask

    // called at a negedge; leaves cmd_valid high and returns at the negedge of LOAD cycle 0
    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, output int acc_cyc);
        cmd_valid = 1'b1; cmd_a_addr = a; cmd_b_addr = b; cmd_c_addr = c;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        chk("accept_ready", cmd_ready, 1'b1);
        acc_cyc = cyc;
        push_exp(a, b, c);
        @(negedge clk);
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            if (!busy) busy_low++;
            @(negedge clk);
        end
        chk("done_seen", dc >= 0, 1'b1);
    endtask

    int west0 [5] = '{1, 2, 0, 0, 0};
    int west1 [5] = '{0, 3, 4, 0, 0};
    int north0[5] = '{5, 7, 0, 0, 0};
    int north1[5] = '{0, 6, 8, 0, 0};
    logic [4:0]  pre_a [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 30, 31};
    logic [15:0] pre_d [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 2, 3};
    int acc1, acc2, acc3, d1, d2, d3;
    logic [15:0] c_ref [4] = '{19, 22, 43, 50};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_a_addr = '0; cmd_b_addr = '0; cmd_c_addr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = pre_a[i]; pre_data = pre_d[i];
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_wr_en", {rd_en, wr_en}, 2'b00);
        chk("rst_ce_clr", {mxu_ce, mxu_clr}, 2'b00);
        chk("rst_operands", {west_input, north_input}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic multiply with skew and latency checks
        issue(5'd0, 5'd4, 5'd8, acc1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mxu_ce) break;
            @(negedge clk);
        end
        chk("feed_start_cycle", cyc - acc1, 10);
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("west0_t%0d", t), west_input[15:0], west0[t]);
            chk($sformatf("west1_t%0d", t), west_input[31:16], west1[t]);
            chk($sformatf("north0_t%0d", t), north_input[15:0], north0[t]);
            chk($sformatf("north1_t%0d", t), north_input[31:16], north1[t]);
            chk($sformatf("ce_t%0d", t), mxu_ce, 1'b1);
            @(negedge clk);
        end
        chk("ce_after_feed", mxu_ce, 1'b0);
        chk("operands_after_feed", {west_input, north_input}, 64'h0);
        wait_done(d1);
        chk("latency", d1 - acc1, 19);
        chk("clr_count", clr_cnt, 1);
        chk("clr_cycle", clr_cyc - acc1, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        for (int k = 0; k < 4; k++) chk($sformatf("mem_c%0d", k), mem[8+k], c_ref[k]);

        // held cmd_valid with changing addresses, back-to-back accepts
        issue(5'd0, 5'd4, 5'd16, acc1);
        cmd_a_addr = 5'd4; cmd_b_addr = 5'd0; cmd_c_addr = 5'd20;
        wait_done(d1);
        chk("held_latency", d1 - acc1, 19);
        issue(5'd4, 5'd0, 5'd20, acc2);
        chk("accept_gap1", acc2 - acc1, 20);
        cmd_a_addr = 5'd0; cmd_b_addr = 5'd4; cmd_c_addr = 5'd24;
        wait_done(d2);
        issue(5'd0, 5'd4, 5'd24, acc3);
        cmd_valid = 1'b0;
        chk("accept_gap2", acc3 - acc2, 20);
        wait_done(d3);
        @(negedge clk);

        // reset in the third FEED cycle aborts the operation
        issue(5'd0, 5'd4, 5'd12, acc1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mxu_ce) break;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_ce", mxu_ce, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_ce", mxu_ce, 1'b0);
        chk("abort_wr_en", wr_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_operands", {west_input, north_input}, 64'h0);
        chk("abort_rd_pending", exp_rd.size(), 0);
        exp_wr.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_abort_idle", {cmd_ready, busy}, 2'b10);
        issue(5'd0, 5'd4, 5'd12, acc1);
        cmd_valid = 1'b0;
        wait_done(d1);
        chk("post_abort_latency", d1 - acc1, 19);
        @(negedge clk);

        // address wrap-around on both reads and writes
        issue(5'd30, 5'd4, 5'd30, acc1);
        cmd_valid = 1'b0;
        wait_done(d1);
        @(negedge clk);
        chk("wrap_mem30", mem[30], 16'd31);
        chk("wrap_mem1", mem[1], 16'd22);

        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("busy_low_while_running", busy_low, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
